// File: rtl/tile_pkg.sv
// tile_pkg: shared constants for the tile renderer.
//   - CPU write-port address map (tile map, pattern RAM, scroll shadows)
//   - RGB565 foreground/background palettes, four entries each
//   - Pipeline latency and tile-map geometry
package tile_pkg;

  localparam int LATENCY  = 3;
  localparam int MAP_COLS = 32;
  localparam int MAP_ROWS = 16;

  localparam logic [10:0] MAP_BASE      = 11'h000;
  localparam logic [10:0] PAT_BASE      = 11'h200;
  localparam logic [10:0] SCROLL_X_ADDR = 11'h400;
  localparam logic [10:0] SCROLL_Y_ADDR = 11'h401;

  // Palette 0 is plain white-on-black; the others are arbitrary but distinct.
  localparam logic [15:0] PAL_FG [4] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F};
  localparam logic [15:0] PAL_BG [4] = '{16'h0000, 16'h0821, 16'h0010, 16'h4000};

endpackage

// File: rtl/tile_ram.sv
// tile_ram: single-clock simple dual-port RAM, read-first.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address (read every cycle)
//   rd_data : registered read data, one cycle after rd_addr
// The array and read register are deliberately not reset so the RAM maps
// onto an iCE40 block RAM.
module tile_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Nonblocking read and write in the same block give read-first behaviour:
  // a read of the address being written returns the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/tile_renderer.sv
// tile_renderer: pixel source for the LCD scan stage.
// Looks up a 32x16 map of 8x8 1bpp tiles at the scrolled scan position and
// returns an RGB565 pixel three clocks after the position is presented.
// Ports:
//   clk, reset         : pixel clock, asynchronous active-high reset
//   hpos, vpos         : scan position from the LCD controller
//   hsync, vsync       : sync strobes from the LCD controller
//   wr_en/addr/data    : CPU write port (map, patterns, scroll shadows)
//   red, green, blue   : registered RGB565 pixel
//   hsync_o, vsync_o   : sync strobes delayed to line up with the pixel
// Build option TILE_RENDERER_HFLIP_EN: map entry bit 7 becomes a horizontal
// flip flag and bit 6 picks palette 0 or 1. Without it bits [7:6] pick one of
// four palettes and tiles are never flipped.
module tile_renderer
  import tile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  hpos,
  input  logic [6:0]  vpos,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        wr_en,
  input  logic [10:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic [4:0]  red,
  output logic [5:0]  green,
  output logic [4:0]  blue,
  output logic        hsync_o,
  output logic        vsync_o
);

  logic [7:0]  scroll_x_q, scroll_x_d;
  logic [6:0]  scroll_y_q, scroll_y_d;
  logic [7:0]  shadow_x_q, shadow_x_d;
  logic [6:0]  shadow_y_q, shadow_y_d;
  logic        vsync_prev_q, vsync_prev_d;

  logic [2:0]  x0_q, x0_d;
  logic [2:0]  y0_q, y0_d;
  logic        valid0_q, valid0_d;

  logic [2:0]  x1_q, x1_d;
  logic [1:0]  pal1_q, pal1_d;
  logic        flip1_q, flip1_d;
  logic        valid1_q, valid1_d;

  logic [15:0] color_q, color_d;
  logic [2:0]  hs_q, hs_d;
  logic [2:0]  vs_q, vs_d;

  logic        map_we, pat_we;
  logic [7:0]  x_sum;
  logic [6:0]  y_sum;
  logic [8:0]  map_rd_addr;
  logic [7:0]  map_rd_data;
  logic [8:0]  pat_rd_addr;
  logic [7:0]  pat_rd_data;
  logic [5:0]  tile_idx;
  logic [1:0]  entry_pal;
  logic        entry_flip;
  logic [2:0]  bit_sel;
  logic        pix_bit;

  // CPU address decode: the top two address bits split map and pattern space,
  // and only the two exact scroll addresses are accepted above that.
  always_comb begin
    map_we = wr_en && (wr_addr[10:9] == MAP_BASE[10:9]);
    pat_we = wr_en && (wr_addr[10:9] == PAT_BASE[10:9]);
  end

  // Stage 0: scrolled coordinates. Wrapping falls out of the fixed widths.
  always_comb begin
    x_sum       = hpos + scroll_x_q;
    y_sum       = vpos + scroll_y_q;
    map_rd_addr = {y_sum[6:3], x_sum[7:3]};
  end

  tile_ram #(.DEPTH(512), .WIDTH(8)) u_map_ram (
    .clk     (clk),
    .wr_en   (map_we),
    .wr_addr (wr_addr[8:0]),
    .wr_data (wr_data),
    .rd_addr (map_rd_addr),
    .rd_data (map_rd_data)
  );

  // Stage 1: split the map entry into tile index, palette and flip flag.
  always_comb begin
    tile_idx = map_rd_data[5:0];
`ifdef TILE_RENDERER_HFLIP_EN
    entry_flip = map_rd_data[7];
    entry_pal  = {1'b0, map_rd_data[6]};
`else
    entry_flip = 1'b0;
    entry_pal  = map_rd_data[7:6];
`endif
    pat_rd_addr = {tile_idx, y0_q};
  end

  tile_ram #(.DEPTH(512), .WIDTH(8)) u_pat_ram (
    .clk     (clk),
    .wr_en   (pat_we),
    .wr_addr (wr_addr[8:0]),
    .wr_data (wr_data),
    .rd_addr (pat_rd_addr),
    .rd_data (pat_rd_data)
  );

  // Stage 3: bit 7 is the leftmost pixel, so unflipped column x reads bit
  // 7-x, which for three bits is simply ~x. The valid flag keeps the output
  // black until real data has flushed through after reset, since the RAM
  // read registers are not cleared.
  always_comb begin
    bit_sel = flip1_q ? x1_q : ~x1_q;
    pix_bit = pat_rd_data[bit_sel];
    color_d = 16'h0000;
    if (valid1_q) begin
      color_d = pix_bit ? PAL_FG[pal1_q] : PAL_BG[pal1_q];
    end
  end

  // Next-state for scroll, pipeline side-band and sync delay lines. Scroll
  // shadows only reach the active registers on a vsync rising edge so a
  // frame is always drawn with one consistent scroll offset.
  always_comb begin
    shadow_x_d   = shadow_x_q;
    shadow_y_d   = shadow_y_q;
    scroll_x_d   = scroll_x_q;
    scroll_y_d   = scroll_y_q;
    vsync_prev_d = vsync;
    if (wr_en && (wr_addr == SCROLL_X_ADDR)) begin
      shadow_x_d = wr_data;
    end
    if (wr_en && (wr_addr == SCROLL_Y_ADDR)) begin
      shadow_y_d = wr_data[6:0];
    end
    if (vsync && !vsync_prev_q) begin
      scroll_x_d = shadow_x_q;
      scroll_y_d = shadow_y_q;
    end

    x0_d     = x_sum[2:0];
    y0_d     = y_sum[2:0];
    valid0_d = 1'b1;

    x1_d     = x0_q;
    pal1_d   = entry_pal;
    flip1_d  = entry_flip;
    valid1_d = valid0_q;

    hs_d = {hs_q[1:0], hsync};
    vs_d = {vs_q[1:0], vsync};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scroll_x_q   <= '0;
      scroll_y_q   <= '0;
      shadow_x_q   <= '0;
      shadow_y_q   <= '0;
      vsync_prev_q <= 1'b0;
      x0_q         <= '0;
      y0_q         <= '0;
      valid0_q     <= 1'b0;
      x1_q         <= '0;
      pal1_q       <= '0;
      flip1_q      <= 1'b0;
      valid1_q     <= 1'b0;
      color_q      <= '0;
      hs_q         <= '0;
      vs_q         <= '0;
    end else begin
      scroll_x_q   <= scroll_x_d;
      scroll_y_q   <= scroll_y_d;
      shadow_x_q   <= shadow_x_d;
      shadow_y_q   <= shadow_y_d;
      vsync_prev_q <= vsync_prev_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      valid0_q     <= valid0_d;
      x1_q         <= x1_d;
      pal1_q       <= pal1_d;
      flip1_q      <= flip1_d;
      valid1_q     <= valid1_d;
      color_q      <= color_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
    end
  end

  assign red     = color_q[15:11];
  assign green   = color_q[10:5];
  assign blue    = color_q[4:0];
  assign hsync_o = hs_q[2];
  assign vsync_o = vs_q[2];

endmodule
